// File: rtl/output_delta.sv
// Backward error-term stage: recomputes y = f(sum) and f'(sum), emits delta = (target - y) * f'(sum).
// Latency 3 cycles (accepting edge is the first); whole pipeline stalls on !out_ready_i while out_valid_o is high.
// Also keeps saturating per-epoch squared-error and sample counters, updated on each output transfer.
module output_delta #(
    parameter int FRAC_BITS = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       activation_i,
    input  logic [31:0]      sum_i,
    input  logic [31:0]      target_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      prediction_o,
    output logic [31:0]      delta_o,
    input  logic             clear_stats_i,
    output logic [31:0]      sq_err_acc_o,
    output logic [CNT_W-1:0] sample_cnt_o
);
    typedef logic signed [31:0] sfp_t;

    localparam logic [2:0] ACT_STEP = 3'd0;
    localparam logic [2:0] ACT_SIG  = 3'd1;
    localparam logic [2:0] ACT_TANH = 3'd2;
    localparam logic [2:0] ACT_RELU = 3'd3;

    localparam sfp_t SFP_MAX = 32'sh7FFF_FFFF;
    localparam sfp_t SFP_MIN = -32'sh8000_0000;
    localparam sfp_t ONE     = sfp_t'(1 << FRAC_BITS);
    localparam sfp_t HALF    = sfp_t'(1 << (FRAC_BITS - 1));
    localparam sfp_t FIVE    = sfp_t'(5 << FRAC_BITS);
    localparam sfp_t K2375   = sfp_t'(19 << (FRAC_BITS - 3));
    localparam sfp_t C0625   = sfp_t'(5 << (FRAC_BITS - 3));
    localparam sfp_t C084375 = sfp_t'(27 << (FRAC_BITS - 5));

    function automatic sfp_t sat_add(input sfp_t a, input sfp_t b);
        logic signed [32:0] s;
        s = $signed({a[31], a}) + $signed({b[31], b});
        if (s[32] != s[31]) return s[32] ? SFP_MIN : SFP_MAX;
        return s[31:0];
    endfunction

    function automatic sfp_t sat_sub(input sfp_t a, input sfp_t b);
        logic signed [32:0] s;
        s = $signed({a[31], a}) - $signed({b[31], b});
        if (s[32] != s[31]) return s[32] ? SFP_MIN : SFP_MAX;
        return s[31:0];
    endfunction

    function automatic sfp_t sat_mul(input sfp_t a, input sfp_t b);
        logic signed [63:0] p;
        logic signed [63:0] q;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        q = p >>> FRAC_BITS;
        if (q[63:31] != {33{q[63]}}) return q[63] ? SFP_MIN : SFP_MAX;
        return q[31:0];
    endfunction

    // Piecewise-linear sigmoid, mirrored about 0.5 for negative inputs.
    function automatic sfp_t sfp_sigmoid(input sfp_t x);
        sfp_t ax;
        sfp_t y;
        ax = x[31] ? sat_sub(32'sd0, x) : x;
        if (ax >= FIVE)       y = ONE;
        else if (ax >= K2375) y = (ax >>> 5) + C084375;
        else if (ax >= ONE)   y = (ax >>> 3) + C0625;
        else                  y = (ax >>> 2) + HALF;
        return x[31] ? ONE - y : y;
    endfunction

    function automatic sfp_t sfp_tanh(input sfp_t x);
        sfp_t s;
        s = sfp_sigmoid(sat_add(x, x));
        return sat_sub(sat_add(s, s), ONE);
    endfunction

    logic       adv;
    logic       xfer;
    logic       v1_q, v2_q, v3_q;
    logic [2:0] act1_q, act2_q;
    sfp_t       sum1_q, tgt1_q, sum2_q, y2_q, err2_q;
    sfp_t       pred3_q, delta3_q, err3_q;
    sfp_t       y_d, err_d, deriv_d, delta_d, sq_term;
    sfp_t       acc_q;
    logic [CNT_W-1:0] cnt_q;

    assign adv  = !v3_q || out_ready_i;
    assign xfer = v3_q && out_ready_i;

    always_comb begin
        y_d = sum1_q;
        case (act1_q)
            ACT_STEP: y_d = (sum1_q > 32'sd0) ? ONE : 32'sd0;
            ACT_SIG:  y_d = sfp_sigmoid(sum1_q);
            ACT_TANH: y_d = sfp_tanh(sum1_q);
            ACT_RELU: y_d = sum1_q[31] ? 32'sd0 : sum1_q;
            default:  y_d = sum1_q;
        endcase
        err_d = sat_sub(tgt1_q, y_d);
    end

    // Step uses a straight-through derivative so training still gets a gradient.
    always_comb begin
        deriv_d = ONE;
        case (act2_q)
            ACT_SIG:  deriv_d = sat_mul(y2_q, sat_sub(ONE, y2_q));
            ACT_TANH: deriv_d = sat_sub(ONE, sat_mul(y2_q, y2_q));
            ACT_RELU: deriv_d = (sum2_q > 32'sd0) ? ONE : 32'sd0;
            default:  deriv_d = ONE;
        endcase
        delta_d = sat_mul(err2_q, deriv_d);
        sq_term = sat_mul(err3_q, err3_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            act1_q   <= '0;
            act2_q   <= '0;
            sum1_q   <= '0;
            tgt1_q   <= '0;
            sum2_q   <= '0;
            y2_q     <= '0;
            err2_q   <= '0;
            pred3_q  <= '0;
            delta3_q <= '0;
            err3_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (adv) begin
                v1_q     <= in_valid_i;
                act1_q   <= activation_i;
                sum1_q   <= sum_i;
                tgt1_q   <= target_i;
                v2_q     <= v1_q;
                act2_q   <= act1_q;
                sum2_q   <= sum1_q;
                y2_q     <= y_d;
                err2_q   <= err_d;
                v3_q     <= v2_q;
                pred3_q  <= y2_q;
                delta3_q <= delta_d;
                err3_q   <= err2_q;
            end
            // A clear coinciding with a transfer keeps only that beat's contribution.
            if (clear_stats_i) begin
                acc_q <= xfer ? sq_term : 32'sd0;
                cnt_q <= xfer ? CNT_W'(1) : '0;
            end else if (xfer) begin
                acc_q <= sat_add(acc_q, sq_term);
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready_o   = adv;
    assign out_valid_o  = v3_q;
    assign prediction_o = pred3_q;
    assign delta_o      = delta3_q;
    assign sq_err_acc_o = acc_q;
    assign sample_cnt_o = cnt_q;
endmodule

// File: tb/tb_output_delta.sv
// Directed self-checking bench for output_delta with hand-computed vectors (FRAC_BITS=16).
module tb_output_delta;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  activation = 3'd0;
    logic [31:0] sum = '0;
    logic [31:0] target = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] prediction;
    logic [31:0] delta;
    logic        clear_stats = 1'b0;
    logic [31:0] sq_err_acc;
    logic [15:0] sample_cnt;

    int errors = 0;
    int checks = 0;

    output_delta #(.FRAC_BITS(16), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .activation_i (activation),
        .sum_i        (sum),
        .target_i     (target),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .prediction_o (prediction),
        .delta_o      (delta),
        .clear_stats_i(clear_stats),
        .sq_err_acc_o (sq_err_acc),
        .sample_cnt_o (sample_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat with out_ready high; returns right after the edge where out_valid should rise.
    task automatic send(input logic [2:0] a, input logic [31:0] s, input logic [31:0] t);
        activation = a;
        sum        = s;
        target     = t;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("latency_early", {31'd0, out_valid}, 32'd0);
        step();
    endtask

    initial begin
        int n_sent;
        int head;
        int accepted;
        logic acc_now;
        logic xfer_now;
        logic [31:0] exp_v;

        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_prediction", prediction, 32'd0);
        chk("rst_delta", delta, 32'd0);
        chk("rst_sq_err", sq_err_acc, 32'd0);
        chk("rst_cnt", {16'd0, sample_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send(3'd1, 32'h0000_0000, 32'h0001_0000);
        chk("sig_valid", {31'd0, out_valid}, 32'd1);
        chk("sig_pred", prediction, 32'h0000_8000);
        chk("sig_delta", delta, 32'h0000_2000);
        step();
        chk("sig_sq", sq_err_acc, 32'h0000_4000);
        chk("sig_cnt", {16'd0, sample_cnt}, 32'd1);
        chk("sig_drained", {31'd0, out_valid}, 32'd0);

        send(3'd3, 32'hFFFF_0000, 32'h0001_0000);
        chk("relu_pred", prediction, 32'd0);
        chk("relu_delta", delta, 32'd0);
        step();
        chk("relu_sq", sq_err_acc, 32'h0001_4000);

        send(3'd2, 32'h0000_0000, 32'h0000_8000);
        chk("tanh_pred", prediction, 32'd0);
        chk("tanh_delta", delta, 32'h0000_8000);
        step();
        chk("tanh_sq", sq_err_acc, 32'h0001_8000);
        chk("tanh_cnt", {16'd0, sample_cnt}, 32'd3);

        send(3'd7, 32'h7FFF_0000, 32'h8001_0000);
        chk("lin_pred", prediction, 32'h7FFF_0000);
        chk("lin_delta", delta, 32'h8000_0000);
        step();
        chk("lin_sq_sat", sq_err_acc, 32'h7FFF_FFFF);
        chk("lin_cnt", {16'd0, sample_cnt}, 32'd4);

        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk("clr_sq", sq_err_acc, 32'd0);
        chk("clr_cnt", {16'd0, sample_cnt}, 32'd0);

        // Six linear beats: y = k, err = -k, delta = -k; stall out_ready in cycles 4..8.
        n_sent   = 0;
        head     = 0;
        accepted = 0;
        activation = 3'd7;
        target     = 32'd0;
        for (int c = 1; c <= 40 && head < 6; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (n_sent < 6);
            sum       = 32'(n_sent + 1) << 16;
            #1;
            if (out_valid) begin
                exp_v = 32'(head + 1) << 16;
                chk("stream_pred", prediction, exp_v);
                chk("stream_delta", delta, -exp_v);
            end
            if (c == 4) begin
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_accepted", 32'(accepted), 32'd3);
            end
            acc_now  = in_valid && in_ready;
            xfer_now = out_valid && out_ready;
            clear_stats = xfer_now && (head == 3);
            step();
            clear_stats = 1'b0;
            if (acc_now) begin
                n_sent++;
                accepted++;
            end
            if (xfer_now) begin
                head++;
                if (head == 4) begin
                    chk("clr_xfer_cnt", {16'd0, sample_cnt}, 32'd1);
                    chk("clr_xfer_sq", sq_err_acc, 32'h0010_0000);
                end
            end
        end
        in_valid = 1'b0;
        chk("stream_done", 32'(head), 32'd6);
        chk("stream_cnt", {16'd0, sample_cnt}, 32'd3);
        chk("stream_sq", sq_err_acc, 32'h004D_0000);

        // Reset with two beats in flight.
        out_ready  = 1'b1;
        activation = 3'd1;
        sum        = 32'h0001_0000;
        in_valid   = 1'b1;
        step();
        sum = 32'h0002_0000;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sq", sq_err_acc, 32'd0);
        chk("mid_rst_cnt", {16'd0, sample_cnt}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_no_output", {31'd0, out_valid}, 32'd0);
        end
        send(3'd1, 32'h0000_0000, 32'h0001_0000);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_pred", prediction, 32'h0000_8000);
        step();
        chk("post_rst_cnt", {16'd0, sample_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
